regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters (ALU result, memory load) using round-robin arbitration with valid/ready handshakes. It drives the register file's write, write-register-number and write-data inputs from registered outputs. It also holds a 32-entry pending-write scoreboard that the issue stage uses to detect read-after-write hazards on both read ports. Sits between the execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/wb_rr_arb.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// Requester indices double as bit positions in the arbiter's valid/grant vectors.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;

   typedef logic [ADDR_W-1:0] reg_num_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam reg_num_t ZERO_REG = '0;

   typedef struct packed {
      reg_num_t rn;
      data_t    data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the issue stage and the register file.
// The slave side is the arbiter; the master side drives requests, claims and read numbers.
interface regfile_wb_arbiter_if;
   import regfile_pkg::*;

   logic     wb_hold;
   logic     req0_valid;
   logic     req0_ready;
   reg_num_t req0_reg;
   data_t    req0_data;
   logic     req1_valid;
   logic     req1_ready;
   reg_num_t req1_reg;
   data_t    req1_data;
   logic     claim_valid;
   reg_num_t claim_reg;
   reg_num_t rd1_reg;
   reg_num_t rd2_reg;
   logic     rd1_busy;
   logic     rd2_busy;
   logic     write;
   reg_num_t writeRegNumber;
   data_t    writeData;

   modport slave (
      input  wb_hold,
      input  req0_valid, req0_reg, req0_data,
      input  req1_valid, req1_reg, req1_data,
      input  claim_valid, claim_reg, rd1_reg, rd2_reg,
      output req0_ready, req1_ready, rd1_busy, rd2_busy,
      output write, writeRegNumber, writeData
   );

   modport master (
      output wb_hold,
      output req0_valid, req0_reg, req0_data,
      output req1_valid, req1_reg, req1_data,
      output claim_valid, claim_reg, rd1_reg, rd2_reg,
      input  req0_ready, req1_ready, rd1_busy, rd2_busy,
      input  write, writeRegNumber, writeData
   );

endinterface

// File: rtl/wb_rr_arb.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes to prio,
// and after every grant prio points at the requester that lost.
module wb_rr_arb
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid_i,
   input  logic       hold_i,
   output logic [1:0] grant_o
);

   logic prio_q;
   logic prio_d;

   // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
   always_comb begin
      grant_o = '0;
      prio_d  = prio_q;
      if (!(hold_i || rst)) begin
         unique case (valid_i)
            2'b01:   grant_o[REQ_ALU]  = 1'b1;
            2'b10:   grant_o[REQ_LOAD] = 1'b1;
            2'b11:   grant_o[prio_q]   = 1'b1;
            default: grant_o           = '0;
         endcase
      end
      if (grant_o[REQ_ALU]) begin
         prio_d = 1'(REQ_LOAD);
      end else if (grant_o[REQ_LOAD]) begin
         prio_d = 1'(REQ_ALU);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'(REQ_ALU);
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and load writebacks, registers the
// winning write, and tracks pending destination registers for read-after-write stalls.
module regfile_wb_arbiter
   import regfile_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);

   logic [1:0]          grant;
   wb_req_t             acc_req;
   logic                write_d;
   logic                write_q;
   reg_num_t            wr_reg_q;
   data_t               wr_data_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] busy_q;

   wb_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid_i ({bus.req1_valid, bus.req0_valid}),
      .hold_i  (bus.wb_hold),
      .grant_o (grant)
   );

   assign bus.req0_ready = grant[REQ_ALU];
   assign bus.req1_ready = grant[REQ_LOAD];

   always_comb begin
      acc_req = grant[REQ_LOAD] ? '{rn: bus.req1_reg, data: bus.req1_data}
                                : '{rn: bus.req0_reg, data: bus.req0_data};
      write_d = (|grant) && (acc_req.rn != ZERO_REG);
   end

   // Clear is applied before set, so re-claiming the committing register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (write_q) begin
         busy_d[wr_reg_q] = 1'b0;
      end
      if (bus.claim_valid && (bus.claim_reg != ZERO_REG)) begin
         busy_d[bus.claim_reg] = 1'b1;
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared on reset like any register.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
      end else begin
         write_q <= write_d;
         if (write_d) begin
            wr_reg_q  <= acc_req.rn;
            wr_data_q <= acc_req.data;
         end
         busy_q <= busy_d;
      end
   end

   assign bus.write          = write_q;
   assign bus.writeRegNumber = wr_reg_q;
   assign bus.writeData      = wr_data_q;
   assign bus.rd1_busy       = busy_q[bus.rd1_reg];
   assign bus.rd2_busy       = busy_q[bus.rd2_reg];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a cycle-level reference
// model of the arbitration, writeback register and pending-write scoreboard.
module tb_regfile_wb_arbiter;

   logic clk;
   logic rst;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int          m_prio;
   bit          m_write;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_busy [32];

   logic obs_r0, obs_r1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int obs_idx();
      if (obs_r0 && !obs_r1) return 0;
      if (obs_r1 && !obs_r0) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_prio  = 0;
      m_write = 0;
      m_addr  = '0;
      m_data  = '0;
      foreach (m_busy[i]) m_busy[i] = 0;
   endtask

   // Check outputs for the inputs currently driven, advance the model, step one clock.
   task automatic cycle(output int acc);
      int          g;
      logic [4:0]  rn;
      logic [31:0] dv;
      #1;
      g = -1;
      if (!rst && !bus.wb_hold) begin
         if (bus.req0_valid && bus.req1_valid) g = m_prio;
         else if (bus.req0_valid)              g = 0;
         else if (bus.req1_valid)              g = 1;
      end
      obs_r0 = bus.req0_ready;
      obs_r1 = bus.req1_ready;
      check("req0_ready", 32'(obs_r0), 32'(g == 0));
      check("req1_ready", 32'(obs_r1), 32'(g == 1));
      check("write", 32'(bus.write), 32'(m_write));
      check("wr_addr", 32'(bus.writeRegNumber), 32'(m_addr));
      check("wr_data", bus.writeData, m_data);
      check("rd1_busy", 32'(bus.rd1_busy), 32'(m_busy[bus.rd1_reg]));
      check("rd2_busy", 32'(bus.rd2_busy), 32'(m_busy[bus.rd2_reg]));
      if (rst) begin
         model_reset();
      end else begin
         if (m_write) m_busy[m_addr] = 0;
         if (bus.claim_valid && bus.claim_reg != 0) m_busy[bus.claim_reg] = 1;
         if (g >= 0) begin
            m_prio = 1 - g;
            rn = (g == 1) ? bus.req1_reg  : bus.req0_reg;
            dv = (g == 1) ? bus.req1_data : bus.req0_data;
            if (rn != 0) begin
               m_write = 1;
               m_addr  = rn;
               m_data  = dv;
            end else begin
               m_write = 0;
            end
         end else begin
            m_write = 0;
         end
      end
      acc = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          acc;
      int          i0, i1, exp_prio;
      logic [4:0]  exp_addr [4];
      exp_addr = '{5'd1, 5'd9, 5'd2, 5'd10};

      rst             = 1'b1;
      bus.wb_hold     = 1'b0;
      bus.req0_valid  = 1'b1;
      bus.req1_valid  = 1'b1;
      bus.req0_reg    = 5'd4;
      bus.req1_reg    = 5'd6;
      bus.req0_data   = 32'h1111_1111;
      bus.req1_data   = 32'h2222_2222;
      bus.claim_valid = 1'b1;
      bus.claim_reg   = 5'd5;
      bus.rd1_reg     = 5'd5;
      bus.rd2_reg     = 5'd9;
      model_reset();
      @(posedge clk);
      #1;

      // reset held with both valid
      cycle(acc);
      bus.rd1_reg = 5'd31;
      cycle(acc);
      check("reset_ready0", 32'(obs_r0), 32'd0);
      check("reset_ready1", 32'(obs_r1), 32'd0);
      check("reset_write", 32'(bus.write), 32'd0);
      rst             = 1'b0;
      bus.req0_valid  = 1'b0;
      bus.req1_valid  = 1'b0;

      // single request
      bus.claim_valid = 1'b1;
      bus.claim_reg   = 5'd5;
      bus.rd1_reg     = 5'd5;
      cycle(acc);
      bus.claim_valid = 1'b0;
      bus.req0_valid  = 1'b1;
      bus.req0_reg    = 5'd5;
      bus.req0_data   = 32'hDEAD_BEEF;
      cycle(acc);
      check("single_ready", 32'(obs_r0), 32'd1);
      bus.req0_valid = 1'b0;
      check("single_write", 32'(bus.write), 32'd1);
      check("single_addr", 32'(bus.writeRegNumber), 32'd5);
      check("single_data", bus.writeData, 32'hDEAD_BEEF);
      check("single_busy_commit", 32'(bus.rd1_busy), 32'd1);
      cycle(acc);
      check("single_busy_after", 32'(bus.rd1_busy), 32'd0);

      // contention from a fresh prio
      rst = 1'b1;
      cycle(acc);
      rst = 1'b0;
      i0 = 0;
      i1 = 0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.req0_reg  = 5'(1 + i0);
         bus.req0_data = 32'hA000_0000 + 32'(i0);
         bus.req1_reg  = 5'(9 + i1);
         bus.req1_data = 32'hB000_0000 + 32'(i1);
         cycle(acc);
         check("cont_grant", 32'(obs_idx()), 32'(k % 2));
         check("cont_addr", 32'(bus.writeRegNumber), 32'(exp_addr[k]));
         if (acc == 0) i0++;
         if (acc == 1) i1++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      cycle(acc);

      // zero register
      bus.req1_valid  = 1'b1;
      bus.req1_reg    = 5'd0;
      bus.req1_data   = 32'h0000_1234;
      bus.claim_valid = 1'b1;
      bus.claim_reg   = 5'd0;
      bus.rd1_reg     = 5'd0;
      cycle(acc);
      check("zero_ready", 32'(obs_r1), 32'd1);
      bus.req1_valid  = 1'b0;
      bus.claim_valid = 1'b0;
      check("zero_write", 32'(bus.write), 32'd0);
      check("zero_busy", 32'(bus.rd1_busy), 32'd0);
      cycle(acc);

      // set/clear collision on r7
      bus.claim_valid = 1'b1;
      bus.claim_reg   = 5'd7;
      bus.rd2_reg     = 5'd7;
      cycle(acc);
      bus.claim_valid = 1'b0;
      bus.req0_valid  = 1'b1;
      bus.req0_reg    = 5'd7;
      bus.req0_data   = 32'hA5A5_5A5A;
      cycle(acc);
      bus.req0_valid  = 1'b0;
      check("coll_write", 32'(bus.write), 32'd1);
      bus.claim_valid = 1'b1;
      cycle(acc);
      bus.claim_valid = 1'b0;
      check("coll_busy", 32'(bus.rd2_busy), 32'd1);
      cycle(acc);
      check("coll_busy_hold", 32'(bus.rd2_busy), 32'd1);

      // hold with both valid
      exp_prio       = m_prio;
      bus.req0_valid = 1'b1;
      bus.req0_reg   = 5'd12;
      bus.req1_valid = 1'b1;
      bus.req1_reg   = 5'd13;
      bus.wb_hold    = 1'b1;
      cycle(acc);
      cycle(acc);
      check("hold_ready0", 32'(obs_r0), 32'd0);
      check("hold_ready1", 32'(obs_r1), 32'd0);
      bus.wb_hold = 1'b0;
      cycle(acc);
      check("hold_prio", 32'(obs_idx()), 32'(exp_prio));
      if (acc == 0) bus.req0_valid = 1'b0;
      if (acc == 1) bus.req1_valid = 1'b0;
      cycle(acc);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      cycle(acc);

      // reset between accept and commit
      bus.claim_valid = 1'b1;
      bus.claim_reg   = 5'd3;
      bus.rd1_reg     = 5'd3;
      cycle(acc);
      bus.claim_valid = 1'b0;
      bus.req0_valid  = 1'b1;
      bus.req0_reg    = 5'd3;
      bus.req0_data   = 32'h3333_0003;
      cycle(acc);
      bus.req0_valid = 1'b0;
      check("midrst_pending", 32'(bus.write), 32'd1);
      rst = 1'b1;
      cycle(acc);
      rst = 1'b0;
      check("midrst_write", 32'(bus.write), 32'd0);
      check("midrst_busy", 32'(bus.rd1_busy), 32'd0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
            bus.req0_valid = 1'b1;
            bus.req0_reg   = 5'($urandom_range(0, 7));
            bus.req0_data  = $urandom;
         end
         if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
            bus.req1_valid = 1'b1;
            bus.req1_reg   = 5'($urandom_range(0, 7));
            bus.req1_data  = $urandom;
         end
         bus.wb_hold     = ($urandom_range(0, 9) == 0);
         rst             = ($urandom_range(0, 49) == 0);
         bus.claim_valid = ($urandom_range(0, 2) == 0);
         bus.claim_reg   = 5'($urandom_range(0, 7));
         bus.rd1_reg     = 5'($urandom_range(0, 7));
         bus.rd2_reg     = 5'($urandom);
         cycle(acc);
         if (acc == 0) bus.req0_valid = 1'b0;
         if (acc == 1) bus.req1_valid = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
